// File: rtl/spi_reg_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : spi_reg_bridge
// Description : Turns framed SPI target bytes into 16-bit register bus reads
//               and writes, and supplies the SPI target's next transmit byte.
//               Frame = CS active. Byte 0 is the command:
//               [7] RD(1)/WR(0), [6] AUTOINC, [5:4] ignored, [3:0] register.
//               Write frames carry (hi, lo) data pairs. Read frames return a
//               status byte followed by (hi, lo) pairs.
// Ports       : clk, reset_n_i          clock, async active-low reset
//               cs_active_i             synchronized chip select (1 = frame)
//               receive_strobe_i/byte_i received byte and its valid pulse
//               transmit_strobe_i       target latched transmit_byte_o
//               transmit_byte_o         byte for the next SPI byte slot
//               bus_addr_o/wdata_o/wr_o register write (1-cycle strobe)
//               bus_rd_o/ack_i/rdata_i  register read handshake
//               overrun_o               sticky: read data was late
// Revision    : 1.0 - initial release
// ============================================================================
module spi_reg_bridge #(
   parameter logic [7:0] STATUS_BYTE = 8'h00,
   parameter int         ADDR_W      = 4
) (
   input  logic              clk,
   input  logic              reset_n_i,
   input  logic              cs_active_i,
   input  logic              receive_strobe_i,
   input  logic [7:0]        receive_byte_i,
   input  logic              transmit_strobe_i,
   output logic [7:0]        transmit_byte_o,
   output logic [ADDR_W-1:0] bus_addr_o,
   output logic [15:0]       bus_wdata_o,
   output logic              bus_wr_o,
   output logic              bus_rd_o,
   input  logic              bus_ack_i,
   input  logic [15:0]       bus_rdata_i,
   output logic              overrun_o
);

   localparam logic [ADDR_W-1:0] c_addr_one = {{(ADDR_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      RX_CMD   = 2'd0,
      RX_HI    = 2'd1,
      RX_LO    = 2'd2,
      RX_RDATA = 2'd3
   } rx_state_t;

   typedef enum logic [1:0] {
      TX_IDLE = 2'd0,
      TX_STAT = 2'd1,
      TX_HI   = 2'd2,
      TX_LO   = 2'd3
   } tx_phase_t;

   rx_state_t r_rx_state;
   tx_phase_t r_tx_phase;
   logic      r_autoinc;
   logic      r_wr_inc;       // advance address the cycle after a write strobe
   logic [7:0] r_hi_byte;     // write data hi byte awaiting its lo partner
   logic [7:0] r_lo_byte;     // read data lo byte awaiting its transmit slot

   always_ff @(posedge clk or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_rx_state      <= RX_CMD;
         r_tx_phase      <= TX_IDLE;
         r_autoinc       <= 1'b0;
         r_wr_inc        <= 1'b0;
         r_hi_byte       <= 8'h00;
         r_lo_byte       <= 8'h00;
         transmit_byte_o <= STATUS_BYTE;
         bus_addr_o      <= '0;
         bus_wdata_o     <= 16'h0000;
         bus_wr_o        <= 1'b0;
         bus_rd_o        <= 1'b0;
         overrun_o       <= 1'b0;
      end else begin
         bus_wr_o <= 1'b0;

         // The write strobe cycle presents the old address; step it afterwards.
         if (r_wr_inc) begin
            bus_addr_o <= bus_addr_o + c_addr_one;
            r_wr_inc   <= 1'b0;
         end

         if (!cs_active_i) begin
            // Frame ended: abandon everything in flight except an issued write.
            r_rx_state      <= RX_CMD;
            r_tx_phase      <= TX_IDLE;
            transmit_byte_o <= STATUS_BYTE;
            bus_rd_o        <= 1'b0;
         end else begin
            // ---------------- receive side ----------------
            if (receive_strobe_i) begin
               case (r_rx_state)
                  RX_CMD: begin
                     r_autoinc  <= receive_byte_i[6];
                     bus_addr_o <= receive_byte_i[ADDR_W-1:0];
                     if (receive_byte_i[7]) begin
                        r_rx_state <= RX_RDATA;
                        r_tx_phase <= TX_STAT;
                        bus_rd_o   <= 1'b1;
                     end else begin
                        r_rx_state <= RX_HI;
                     end
                  end
                  RX_HI: begin
                     r_hi_byte  <= receive_byte_i;
                     r_rx_state <= RX_LO;
                  end
                  RX_LO: begin
                     bus_wr_o    <= 1'b1;
                     bus_wdata_o <= {r_hi_byte, receive_byte_i};
                     r_wr_inc    <= r_autoinc;
                     r_rx_state  <= RX_HI;
                  end
                  default: begin
                     // RX_RDATA: initiator clocks out dummy bytes; discard.
                  end
               endcase
            end

            // ---------------- read completion ----------------
            // Evaluated before the transmit strobe so a same-cycle strobe
            // sees the freshly loaded hi byte and no overrun is flagged.
            if (bus_ack_i && bus_rd_o) begin
               bus_rd_o        <= 1'b0;
               r_lo_byte       <= bus_rdata_i[7:0];
               transmit_byte_o <= bus_rdata_i[15:8];
            end

            // ---------------- transmit side ----------------
            if (transmit_strobe_i) begin
               case (r_tx_phase)
                  TX_STAT: begin
                     if (bus_rd_o && !bus_ack_i) begin
                        overrun_o       <= 1'b1;
                        transmit_byte_o <= STATUS_BYTE;
                     end
                     r_tx_phase <= TX_HI;
                  end
                  TX_HI: begin
                     transmit_byte_o <= r_lo_byte;
                     r_tx_phase      <= TX_LO;
                  end
                  TX_LO: begin
                     transmit_byte_o <= STATUS_BYTE;
                     r_tx_phase      <= TX_HI;
                     if (bus_rd_o && !bus_ack_i) begin
                        // Previous read still outstanding: keep waiting on it.
                        overrun_o <= 1'b1;
                     end else begin
                        if (r_autoinc) begin
                           bus_addr_o <= bus_addr_o + c_addr_one;
                        end
                        bus_rd_o <= 1'b1;
                     end
                  end
                  default: begin
                     // TX_IDLE: no read frame in progress.
                  end
               endcase
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_spi_reg_bridge
// Description : Directed self-checking bench for spi_reg_bridge. Each task
//               drives one scenario and compares outputs against hand-derived
//               values. STATUS_BYTE is overridden to 8'hA5 so that status
//               slots are distinguishable from cleared data.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_reg_bridge;

   localparam logic [7:0] STAT = 8'hA5;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        cs_active = 1'b0;
   logic        receive_strobe = 1'b0;
   logic [7:0]  receive_byte = 8'h00;
   logic        transmit_strobe = 1'b0;
   logic [7:0]  transmit_byte;
   logic [3:0]  bus_addr;
   logic [15:0] bus_wdata;
   logic        bus_wr;
   logic        bus_rd;
   logic        bus_ack = 1'b0;
   logic [15:0] bus_rdata = 16'h0000;
   logic        overrun;

   int checks = 0;
   int errors = 0;

   // Bus write log and read-request activity, sampled mid-cycle.
   int          wr_cnt = 0;
   int          rd_cycles = 0;
   logic [3:0]  wr_addr_q[$];
   logic [15:0] wr_data_q[$];

   spi_reg_bridge #(
      .STATUS_BYTE(STAT),
      .ADDR_W     (4)
   ) dut (
      .clk              (clk),
      .reset_n_i        (reset_n),
      .cs_active_i      (cs_active),
      .receive_strobe_i (receive_strobe),
      .receive_byte_i   (receive_byte),
      .transmit_strobe_i(transmit_strobe),
      .transmit_byte_o  (transmit_byte),
      .bus_addr_o       (bus_addr),
      .bus_wdata_o      (bus_wdata),
      .bus_wr_o         (bus_wr),
      .bus_rd_o         (bus_rd),
      .bus_ack_i        (bus_ack),
      .bus_rdata_i      (bus_rdata),
      .overrun_o        (overrun)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus_wr) begin
         wr_cnt++;
         wr_addr_q.push_back(bus_addr);
         wr_data_q.push_back(bus_wdata);
      end
      if (bus_rd) rd_cycles++;
   end

   // ---------------- stimulus helpers (called at a negedge) ----------------
   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_rx(input logic [7:0] b);
      receive_byte   = b;
      receive_strobe = 1'b1;
      @(negedge clk);
      receive_strobe = 1'b0;
   endtask

   task automatic send_tx();
      transmit_strobe = 1'b1;
      @(negedge clk);
      transmit_strobe = 1'b0;
   endtask

   task automatic send_ack(input logic [15:0] d);
      bus_ack   = 1'b1;
      bus_rdata = d;
      @(negedge clk);
      bus_ack   = 1'b0;
   endtask

   task automatic set_cs(input logic v);
      cs_active = v;
      @(negedge clk);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      checks++; if (transmit_byte !== STAT) begin errors++; $display("FAIL reset_tx: got %h expected %h", transmit_byte, STAT); end
      checks++; if (bus_wr !== 1'b0) begin errors++; $display("FAIL reset_wr: got %b expected 0", bus_wr); end
      checks++; if (bus_rd !== 1'b0) begin errors++; $display("FAIL reset_rd: got %b expected 0", bus_rd); end
      checks++; if (bus_addr !== 4'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", bus_addr); end
      checks++; if (bus_wdata !== 16'h0000) begin errors++; $display("FAIL reset_wdata: got %h expected 0000", bus_wdata); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
   endtask

   task automatic test_write();
      int wr0 = wr_cnt;
      int rd0 = rd_cycles;
      set_cs(1'b1);
      send_rx(8'h03); idle(4);
      send_rx(8'h12); idle(4);
      send_rx(8'h34);
      checks++; if (bus_wr !== 1'b1) begin errors++; $display("FAIL wr_pulse: got %b expected 1", bus_wr); end
      checks++; if (bus_addr !== 4'h3) begin errors++; $display("FAIL wr_addr: got %h expected 3", bus_addr); end
      checks++; if (bus_wdata !== 16'h1234) begin errors++; $display("FAIL wr_data: got %h expected 1234", bus_wdata); end
      idle(1);
      checks++; if (bus_wr !== 1'b0) begin errors++; $display("FAIL wr_pulse_end: got %b expected 0", bus_wr); end
      checks++; if (bus_addr !== 4'h3) begin errors++; $display("FAIL wr_no_inc: got %h expected 3", bus_addr); end
      set_cs(1'b0);
      checks++; if (wr_cnt - wr0 !== 1) begin errors++; $display("FAIL wr_count: got %0d expected 1", wr_cnt - wr0); end
      checks++; if (rd_cycles - rd0 !== 0) begin errors++; $display("FAIL wr_no_read: got %0d expected 0", rd_cycles - rd0); end
   endtask

   task automatic test_autoinc_write();
      int wr0 = wr_cnt;
      set_cs(1'b1);
      send_rx(8'h4F);
      checks++; if (bus_addr !== 4'hF) begin errors++; $display("FAIL aw_cmd_addr: got %h expected f", bus_addr); end
      idle(3); send_rx(8'h11); idle(3); send_rx(8'h22);
      idle(1);
      checks++; if (bus_addr !== 4'h0) begin errors++; $display("FAIL aw_wrap: got %h expected 0", bus_addr); end
      idle(2); send_rx(8'h33); idle(3); send_rx(8'h44);
      idle(3); send_rx(8'h55);
      idle(4);
      set_cs(1'b0);
      checks++; if (wr_cnt - wr0 !== 2) begin errors++; $display("FAIL aw_count: got %0d expected 2", wr_cnt - wr0); end
      if (wr_cnt - wr0 >= 2) begin
         checks++; if (wr_addr_q[wr0] !== 4'hF) begin errors++; $display("FAIL aw_addr0: got %h expected f", wr_addr_q[wr0]); end
         checks++; if (wr_data_q[wr0] !== 16'h1122) begin errors++; $display("FAIL aw_data0: got %h expected 1122", wr_data_q[wr0]); end
         checks++; if (wr_addr_q[wr0+1] !== 4'h0) begin errors++; $display("FAIL aw_addr1: got %h expected 0", wr_addr_q[wr0+1]); end
         checks++; if (wr_data_q[wr0+1] !== 16'h3344) begin errors++; $display("FAIL aw_data1: got %h expected 3344", wr_data_q[wr0+1]); end
      end
      checks++; if (bus_addr !== 4'h1) begin errors++; $display("FAIL aw_final_addr: got %h expected 1", bus_addr); end
   endtask

   task automatic test_read();
      set_cs(1'b1);
      send_rx(8'h85);
      checks++; if (bus_rd !== 1'b1) begin errors++; $display("FAIL rd_req: got %b expected 1", bus_rd); end
      checks++; if (bus_addr !== 4'h5) begin errors++; $display("FAIL rd_addr: got %h expected 5", bus_addr); end
      checks++; if (transmit_byte !== STAT) begin errors++; $display("FAIL rd_status_slot: got %h expected %h", transmit_byte, STAT); end
      idle(4);
      send_ack(16'hBEEF);
      checks++; if (bus_rd !== 1'b0) begin errors++; $display("FAIL rd_ack_drop: got %b expected 0", bus_rd); end
      checks++; if (transmit_byte !== 8'hBE) begin errors++; $display("FAIL rd_hi_load: got %h expected be", transmit_byte); end
      idle(2);
      send_ack(16'h1234);
      checks++; if (transmit_byte !== 8'hBE) begin errors++; $display("FAIL rd_stray_ack: got %h expected be", transmit_byte); end
      idle(3); send_tx();
      checks++; if (transmit_byte !== 8'hBE) begin errors++; $display("FAIL rd_stat_strobe: got %h expected be", transmit_byte); end
      idle(3); send_tx();
      checks++; if (transmit_byte !== 8'hEF) begin errors++; $display("FAIL rd_lo_slot: got %h expected ef", transmit_byte); end
      idle(3); send_tx();
      checks++; if (transmit_byte !== STAT) begin errors++; $display("FAIL rd_next_status: got %h expected %h", transmit_byte, STAT); end
      checks++; if (bus_rd !== 1'b1) begin errors++; $display("FAIL rd_reread: got %b expected 1", bus_rd); end
      checks++; if (bus_addr !== 4'h5) begin errors++; $display("FAIL rd_same_addr: got %h expected 5", bus_addr); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rd_overrun: got %b expected 0", overrun); end
      set_cs(1'b0);
      checks++; if (bus_rd !== 1'b0) begin errors++; $display("FAIL rd_cs_drop: got %b expected 0", bus_rd); end
   endtask

   task automatic test_ack_strobe_same_cycle();
      set_cs(1'b1);
      send_rx(8'h81);
      idle(2);
      bus_ack = 1'b1; bus_rdata = 16'h5A6B; transmit_strobe = 1'b1;
      @(negedge clk);
      bus_ack = 1'b0; transmit_strobe = 1'b0;
      checks++; if (transmit_byte !== 8'h5A) begin errors++; $display("FAIL same_hi: got %h expected 5a", transmit_byte); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL same_overrun: got %b expected 0", overrun); end
      idle(2); send_tx();
      checks++; if (transmit_byte !== 8'h6B) begin errors++; $display("FAIL same_lo: got %h expected 6b", transmit_byte); end
      set_cs(1'b0);
   endtask

   task automatic test_cs_abort();
      int wr0 = wr_cnt;
      set_cs(1'b1);
      send_rx(8'h01); idle(2);
      send_rx(8'h77); idle(2);
      set_cs(1'b0);
      idle(3);
      checks++; if (wr_cnt - wr0 !== 0) begin errors++; $display("FAIL abort_no_wr: got %0d expected 0", wr_cnt - wr0); end
      checks++; if (transmit_byte !== STAT) begin errors++; $display("FAIL abort_tx: got %h expected %h", transmit_byte, STAT); end
      set_cs(1'b1);
      send_rx(8'h06);
      checks++; if (bus_addr !== 4'h6) begin errors++; $display("FAIL abort_new_cmd: got %h expected 6", bus_addr); end
      idle(2); send_rx(8'h9A); idle(2); send_rx(8'hBC);
      checks++; if (bus_wr !== 1'b1) begin errors++; $display("FAIL abort_wr: got %b expected 1", bus_wr); end
      checks++; if (bus_wdata !== 16'h9ABC) begin errors++; $display("FAIL abort_wdata: got %h expected 9abc", bus_wdata); end
      set_cs(1'b0);
   endtask

   task automatic test_autoinc_read_overrun();
      set_cs(1'b1);
      send_rx(8'hC2);
      checks++; if (bus_addr !== 4'h2) begin errors++; $display("FAIL ar_addr: got %h expected 2", bus_addr); end
      idle(4);
      send_ack(16'hA1B2);
      checks++; if (transmit_byte !== 8'hA1) begin errors++; $display("FAIL ar_hi0: got %h expected a1", transmit_byte); end
      idle(2); send_tx();
      idle(2); send_tx();
      checks++; if (transmit_byte !== 8'hB2) begin errors++; $display("FAIL ar_lo0: got %h expected b2", transmit_byte); end
      idle(2); send_tx();
      checks++; if (bus_addr !== 4'h3) begin errors++; $display("FAIL ar_inc: got %h expected 3", bus_addr); end
      checks++; if (bus_rd !== 1'b1) begin errors++; $display("FAIL ar_rd2: got %b expected 1", bus_rd); end
      idle(6);
      checks++; if (transmit_byte !== STAT) begin errors++; $display("FAIL ar_late_slot: got %h expected %h", transmit_byte, STAT); end
      send_tx();
      idle(2); send_tx();
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ar_overrun: got %b expected 1", overrun); end
      checks++; if (bus_rd !== 1'b1) begin errors++; $display("FAIL ar_rd_held: got %b expected 1", bus_rd); end
      checks++; if (bus_addr !== 4'h3) begin errors++; $display("FAIL ar_no_inc: got %h expected 3", bus_addr); end
      checks++; if (transmit_byte !== STAT) begin errors++; $display("FAIL ar_ovr_slot: got %h expected %h", transmit_byte, STAT); end
      idle(3);
      send_ack(16'hC3D4);
      checks++; if (transmit_byte !== 8'hC3) begin errors++; $display("FAIL ar_late_hi: got %h expected c3", transmit_byte); end
      checks++; if (bus_rd !== 1'b0) begin errors++; $display("FAIL ar_late_drop: got %b expected 0", bus_rd); end
      set_cs(1'b0);
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ar_sticky: got %b expected 1", overrun); end
   endtask

   task automatic test_async_reset();
      set_cs(1'b1);
      send_rx(8'h87);
      checks++; if (bus_rd !== 1'b1) begin errors++; $display("FAIL ar_pre_rd: got %b expected 1", bus_rd); end
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      checks++; if (bus_rd !== 1'b0) begin errors++; $display("FAIL areset_rd: got %b expected 0", bus_rd); end
      checks++; if (bus_addr !== 4'h0) begin errors++; $display("FAIL areset_addr: got %h expected 0", bus_addr); end
      checks++; if (bus_wdata !== 16'h0000) begin errors++; $display("FAIL areset_wdata: got %h expected 0000", bus_wdata); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL areset_overrun: got %b expected 0", overrun); end
      checks++; if (transmit_byte !== STAT) begin errors++; $display("FAIL areset_tx: got %h expected %h", transmit_byte, STAT); end
      cs_active = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      idle(2);
   endtask

   initial begin
      idle(3);
      test_reset();
      reset_n = 1'b1;
      idle(2);
      test_write();
      idle(2);
      test_autoinc_write();
      idle(2);
      test_read();
      idle(2);
      test_ack_strobe_same_cycle();
      idle(2);
      test_cs_abort();
      idle(2);
      test_autoinc_read_overrun();
      idle(2);
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
